fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write arbiter that shares one fifo write port between N_REQ requesters.
//   Grants one requester at a time and forwards its data to the FIFO while the FIFO is not full.
//   Caps each tenure at MAX_BURST accepted beats to bound latency for the other requesters.
//   Sits directly in front of the fifo write side (drives wr_en/data_in, observes full).
// PARAMETERS
//   WIDTH      8   data width; equals the FIFO WIDTH
//   N_REQ      4   number of requesters; legal range >= 2
//   MAX_BURST  4   max accepted beats per grant tenure; legal range >= 1
// PORTS
//   clk          in   1            rising-edge clock
//   reset        in   1            asynchronous, active-high reset
//   req          in   N_REQ        req[i]=1: requester i has a beat to write
//   req_data     in   N_REQ*WIDTH  beat of requester i on bits [i*WIDTH +: WIDTH]
//   ack          out  N_REQ        one-hot pulse: beat of the owner accepted this cycle
//   grant        out  N_REQ        one-hot current owner; all zero in IDLE
//   busy         out  1            1 while in GRANT
//   fifo_full    in   1            FIFO full flag
//   fifo_wr_en   out  1            FIFO write enable
//   fifo_data_in out  WIDTH        FIFO write data
// BEHAVIOUR
//   Reset (async, any time, including mid-tenure):
//   - state=IDLE; grant=0, ack=0, busy=0, fifo_wr_en=0, fifo_data_in=0.
//   - beat_cnt=0; last_owner=N_REQ-1, so req[0] has top priority first.
//   State IDLE:
//   - If req != 0, select the first i with req[i]=1, searching from last_owner+1 and wrapping mod N_REQ.
//   - Register owner=i; next cycle state=GRANT, beat_cnt=0.
//   - Arbitration latency is 1 cycle. No beat is accepted in IDLE.
//   State GRANT (owner o):
//   - grant=onehot(o), busy=1.
//   - fifo_data_in = req_data[o] (combinational).
//   - accept = req[o] & ~fifo_full. fifo_wr_en = accept. ack[o] = accept (same cycle, combinational).
//   - On accept: beat_cnt <= beat_cnt+1. beat_cnt width is $clog2(MAX_BURST+1); it never wraps.
//   - fifo_full=1: no write, no ack, beat_cnt holds, grant held. Stalls are unbounded and never lose a beat.
//   - Release when req[o]=0, or when accept and beat_cnt==MAX_BURST-1.
//     On release: last_owner<=o, beat_cnt<=0, state<=IDLE.
//     The accepted beat in the release cycle is still written.
//   - Re-arbitration always costs one IDLE bubble cycle.
//   Other rules:
//   - Requester rule: hold req[i] and req_data stable until ack[i]. Dropping req before ack withdraws the beat.
//   - Simultaneous requests are resolved by the rotation only. The last owner has lowest priority next round.
//   - A lone requester is re-granted after the one-cycle bubble.
//   - Outputs other than ack, fifo_wr_en and fifo_data_in are registered.
//   - Never issues fifo_wr_en while fifo_full=1. At most one ack bit is set per cycle.
// TESTING
//   1 Reset, then req=4'b0001 held, full=0, MAX_BURST=4 -> grant0 after 1 cycle;
//     4 acks on consecutive cycles; IDLE bubble; re-grant0.
//   2 req=4'b1111 continuous, full=0 -> tenure order 0,1,2,3,0;
//     each tenure 4 beats, fifo_data_in = owner's data.
//   3 Owner 2 mid-burst (2 beats done), full=1 for 3 cycles -> no wr_en/ack;
//     after full=0 the remaining 2 beats are written; total 4.
//   4 Owner 1 drops req after 1 beat while req3=1 -> release; IDLE; grant3.
//   5 Assert reset mid-tenure of owner 3 -> outputs 0 immediately;
//     after release with req=4'b1001, grant0 first.
//   6 Random req/full, 10k cycles -> scoreboard: FIFO contents equal the acked beats in order;
//     no write while full; wait <= (N_REQ-1)*(MAX_BURST+1) granted cycles when full=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port between N_REQ
// requesters, one owner at a time, with each tenure capped at MAX_BURST
// accepted beats. The owner's data is forwarded to the FIFO while it is not full.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data_in
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [OW-1:0]    LAST_RST  = OW'(N_REQ - 1);
    localparam logic [CW-1:0]    BEAT_LAST = CW'(MAX_BURST - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_owner_q, last_owner_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              busy_q, busy_d;

    logic              accept_s;
    logic              pick_found_s;
    logic [OW-1:0]     pick_idx_s;
    logic [OW-1:0]     cand_s;
    logic [WIDTH-1:0]  data_s;

    // A beat is accepted only from the current owner and only while the FIFO has room.
    assign accept_s = (state_q == ST_GRANT) && req[owner_q] && !fifo_full;

    // Combinational outputs: ack and write strobe follow the accept in the same cycle.
    assign ack          = accept_s ? grant_q : {N_REQ{1'b0}};
    assign fifo_wr_en   = accept_s;
    assign fifo_data_in = (state_q == ST_GRANT) ? data_s : {WIDTH{1'b0}};
    assign grant        = grant_q;
    assign busy         = busy_q;

    // Select the owner's data slice with constant indices only.
    always_comb begin
        data_s = {WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            data_s = (owner_q == OW'(i)) ? req_data[i*WIDTH +: WIDTH] : data_s;
        end
    end

    // Rotating priority search starting just after the last owner.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = owner_q;
        cand_s       = owner_q;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_s = OW'((int'(last_owner_q) + k) % N_REQ);
            if (!pick_found_s && req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state logic: arbitration in IDLE, beat counting and release in GRANT.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx_s;
                    beat_cnt_d = {CW{1'b0}};
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // The beat accepted in the release cycle is still written.
                if (!req[owner_q] || (accept_s && (beat_cnt_q == BEAT_LAST))) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    beat_cnt_d   = {CW{1'b0}};
                end else if (accept_s) begin
                    beat_cnt_d   = beat_cnt_q + CW'(1);
                end else begin
                    beat_cnt_d   = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = {CW{1'b0}};
            end
        endcase
        grant_d = (state_d == ST_GRANT) ? (ONE_HOT0 << owner_d) : {N_REQ{1'b0}};
        busy_d  = (state_d == ST_GRANT);
    end

    // State, arbitration history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= {OW{1'b0}};
            last_owner_q <= LAST_RST;
            beat_cnt_q   <= {CW{1'b0}};
            grant_q      <= {N_REQ{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus
// a per-cycle behavioural model, a FIFO-order scoreboard and a wait-bound check.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 8;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;
    localparam int WAIT_BOUND = (N_REQ - 1) * (MAX_BURST + 1) + 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] req_data = '0;
    logic                   fifo_full = 1'b0;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   fifo_wr_en;
    logic [WIDTH-1:0]       fifo_data_in;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .grant(grant), .busy(busy), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit             m_busy = 1'b0;
    int             m_owner = 0;
    int             m_beats = 0;
    int             m_last = N_REQ - 1;
    logic [7:0]     exp_q[$];
    logic [7:0]     got_q[$];
    int             wait_cnt[N_REQ];
    int             max_wait = 0;
    bit             rnd_on = 1'b0;

    logic [3:0] eg, ea;
    logic       ew;
    logic [7:0] ed;
    bit         acc, found;
    int         w;

    // Compare DUT outputs to the model each cycle, then advance the model over the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_owner = 0; m_beats = 0; m_last = N_REQ - 1;
            acc = 1'b0; eg = 4'h0; ea = 4'h0; ew = 1'b0; ed = 8'h00;
        end else begin
            acc = m_busy && req[m_owner] && !fifo_full;
            eg  = m_busy ? 4'(1 << m_owner) : 4'h0;
            ea  = acc ? eg : 4'h0;
            ew  = acc;
            ed  = m_busy ? req_data[m_owner*8 +: 8] : 8'h00;
        end
        chk("m_grant", grant, eg);
        chk("m_busy", busy, m_busy);
        chk("m_ack", ack, ea);
        chk("m_wr_en", fifo_wr_en, ew);
        chk("m_data", fifo_data_in, ed);
        chk("no_wr_while_full", fifo_wr_en & fifo_full, 1'b0);
        if (fifo_wr_en) got_q.push_back(fifo_data_in);
        if (!reset) begin
            if (acc) exp_q.push_back(req_data[m_owner*8 +: 8]);
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 1; k <= N_REQ; k++) begin
                    w = (m_last + k) % N_REQ;
                    if (!found && req[w]) begin
                        found = 1'b1;
                        m_owner = w;
                    end
                end
                if (found) begin
                    m_busy = 1'b1;
                    m_beats = 0;
                end
            end else begin
                if (acc) m_beats++;
                if (!req[m_owner] || m_beats == MAX_BURST) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                    m_beats = 0;
                end
            end
            if (rnd_on) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant[i] || !req[i]) wait_cnt[i] = 0;
                    else if (!fifo_full) wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_chk(input string nm, input logic [3:0] g, input logic [3:0] a);
        @(negedge clk);
        chk({nm, "_grant"}, grant, g);
        chk({nm, "_ack"}, ack, a);
        tick();
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int          owners[$];
    int          beats[$];
    logic [3:0]  prev_g;
    logic [3:0]  ack_s;
    int          oidx;
    int          nmis;
    int          exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0]  t3_g[9] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    logic [3:0]  t3_a[9] = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};

    initial begin
        // Reset: outputs quiet even with every requester active.
        reset = 1'b1;
        req = 4'b1111;
        req_data = 32'hC3C2C1C0;
        tick();
        @(negedge clk);
        chk("rst_grant", grant, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 4'h0);
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        chk("rst_data", fifo_data_in, 8'h00);
        tick();

        // 1: lone requester 0, full burst, bubble, re-grant.
        reset = 1'b0;
        req = 4'b0001;
        cyc_chk("t1_arb", 4'h0, 4'h0);
        for (int i = 0; i < MAX_BURST; i++) cyc_chk("t1_beat", 4'h1, 4'h1);
        cyc_chk("t1_bubble", 4'h0, 4'h0);
        cyc_chk("t1_regrant", 4'h1, 4'h1);
        req = 4'b0000;
        cyc_chk("t1_drop", 4'h1, 4'h0);
        cyc_chk("t1_idle", 4'h0, 4'h0);

        // 2: all requesting -> tenures 0,1,2,3,0 of MAX_BURST beats each.
        reset_pulse();
        req = 4'b1111;
        prev_g = 4'h0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            oidx = 0;
            for (int i = 0; i < N_REQ; i++) if (grant[i]) oidx = i;
            if (grant != 4'h0 && prev_g == 4'h0) begin
                owners.push_back(oidx);
                beats.push_back(0);
            end
            if (ack != 4'h0 && beats.size() > 0) begin
                beats[beats.size()-1]++;
                chk("t2_data", fifo_data_in, 32'hC0 | oidx);
            end
            prev_g = grant;
            tick();
        end
        chk("t2_ntenures", owners.size(), 5);
        for (int t = 0; t < 5 && t < owners.size(); t++) begin
            chk("t2_owner", owners[t], exp_order[t]);
            chk("t2_beats", beats[t], MAX_BURST);
        end

        // 3: owner 2 stalled by full for 3 cycles mid-burst.
        reset_pulse();
        req = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            cyc_chk("t3", t3_g[c], t3_a[c]);
        end
        req = 4'b0000;
        fifo_full = 1'b0;

        // 4: owner 1 withdraws after one beat, requester 3 takes over.
        reset_pulse();
        req = 4'b1010;
        cyc_chk("t4_arb", 4'h0, 4'h0);
        cyc_chk("t4_beat", 4'h2, 4'h2);
        req = 4'b1000;
        cyc_chk("t4_release", 4'h2, 4'h0);
        cyc_chk("t4_bubble", 4'h0, 4'h0);
        cyc_chk("t4_grant3", 4'h8, 4'h8);

        // 5: reset in the middle of owner 3's tenure.
        cyc_chk("t5_beat", 4'h8, 4'h8);
        reset = 1'b1;
        #1;
        chk("t5_rst_grant", grant, 4'h0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ack", ack, 4'h0);
        chk("t5_rst_wr_en", fifo_wr_en, 1'b0);
        tick();
        reset = 1'b0;
        req = 4'b1001;
        cyc_chk("t5_arb", 4'h0, 4'h0);
        cyc_chk("t5_grant0", 4'h1, 4'h1);
        req = 4'b0000;
        tick();
        tick();

        // 6: random traffic honouring the hold-until-ack rule.
        for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
        rnd_on = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            ack_s = ack;
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (ack_s[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    req_data[i*8 +: 8] = 8'($urandom);
                end else if (!req[i]) begin
                    req[i] = ($urandom_range(0, 2) == 0);
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
        end
        rnd_on = 1'b0;
        req = 4'b0000;
        fifo_full = 1'b0;
        for (int c = 0; c < 10; c++) tick();

        chk("sb_count", got_q.size(), exp_q.size());
        chk("sb_traffic", (exp_q.size() > 1000), 1'b1);
        nmis = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nmis++;
        chk("sb_order_mismatches", nmis, 0);
        chk("wait_bound", (max_wait <= WAIT_BOUND), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
